// File: rtl/mem_defines.sv
`default_nettype none
// mem_defines: shared access-size/state types, width constants and the
// alignment rule used by the lsu_mem_resp responder.
package mem_defines;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    localparam int MEM_W_END = 31;
    localparam int MASK_END  = 3;

    // Size code 3 has no legal encoding and is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            2'(SIZE_B): mis = 1'b0;
            2'(SIZE_H): mis = addr_lo[0];
            2'(SIZE_W): mis = (addr_lo != 2'b00);
            default:    mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// mem_array: DEPTH x 32 word storage with byte-lane write enables and a
// registered read port that holds its value until the next read.
module mem_array
    import mem_defines::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [MEM_W_END:0]       wdata,
    input  logic [MASK_END:0]        wmask,
    output logic [MEM_W_END:0]       rdata
);

    logic [MEM_W_END:0] mem_q [DEPTH];
    logic [MEM_W_END:0] rdata_q;

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i <= MASK_END; i++) begin
                if (wmask[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/lsu_mem_resp.sv
`default_nettype none
// lsu_mem_resp: fixed-latency memory responder for the LSU request/response port.
// Define RAND_LAT_EN to add 0..3 pseudo-random extra cycles of latency per access.
module lsu_mem_resp
    import mem_defines::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               reqValid,
    input  logic [31:0]        addr,
    input  logic [1:0]         size,
    input  logic               wen,
    input  logic [MEM_W_END:0] wdata,
    input  logic [MASK_END:0]  wmask,
    output logic               respValid,
    output logic [MEM_W_END:0] rdata,
    output logic               err_overrun,
    output logic               err_misalign
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 5;

    resp_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic               err_ovr_q, err_ovr_d;
    logic               err_mis_q, err_mis_d;

    logic               accept;
    logic               overrun;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   eff_lat;
    logic [MEM_W_END:0] mem_rdata;

    assign accept  = reqValid && (state_q != BUSY);
    assign overrun = reqValid && (state_q == BUSY);

    // Out-of-range addresses simply wrap onto the array.
    assign idx = IDX_W'((addr - BASE_ADDR) >> 2);

`ifdef RAND_LAT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign eff_lat = CNT_W'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
    assign eff_lat = CNT_W'(LATENCY);
`endif

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (accept && wen),
        .re      (accept && !wen),
        .idx     (idx),
        .wdata   (wdata),
        .wmask   (wmask),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            err_ovr_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            err_ovr_q <= err_ovr_d;
            err_mis_q <= err_mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        err_ovr_d = err_ovr_q;
        err_mis_d = err_mis_q;

        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A request in RESP is taken exactly as in IDLE, overriding the return to IDLE.
        if (accept) begin
            state_d   = (eff_lat == CNT_W'(1)) ? RESP : BUSY;
            cnt_d     = eff_lat - CNT_W'(1);
            is_load_d = !wen;
            if (is_misaligned(size, addr[1:0])) begin
                err_mis_d = 1'b1;
            end
        end

        if (overrun) begin
            err_ovr_d = 1'b1;
        end
    end

    always_comb begin
        respValid    = (state_q == RESP);
        rdata        = (state_q == RESP && is_load_q) ? mem_rdata : '0;
        err_overrun  = err_ovr_q;
        err_misalign = err_mis_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_resp.sv
`default_nettype none
// tb_lsu_mem_resp: directed vector table, reset corner cases and randomized
// traffic checked against a transaction-level model of the responder.
module tb_lsu_mem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        reqValid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        respValid;
    logic [31:0] rdata;
    logic        err_overrun;
    logic        err_misalign;

    lsu_mem_resp #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .reqValid     (reqValid),
        .addr         (addr),
        .size         (size),
        .wen          (wen),
        .wdata        (wdata),
        .wmask        (wmask),
        .respValid    (respValid),
        .rdata        (rdata),
        .err_overrun  (err_overrun),
        .err_misalign (err_misalign)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction with a due cycle, plus the array.
    logic [31:0] m_mem [DEPTH];
    bit          m_pend;
    int          m_due;
    logic [31:0] m_data;
    bit          m_ovr, m_mis;
    int          cyc = 0;
    bit          chk_model;

    function automatic int m_idx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    task automatic m_reset();
        m_pend = 0;
        m_ovr  = 0;
        m_mis  = 0;
    endtask

    task automatic step(input logic rq, input logic [31:0] a, input logic [1:0] sz,
                        input logic we, input logic [31:0] wd, input logic [3:0] wm);
        bit          e_resp;
        logic [31:0] e_rd;
        int          ix;
        @(posedge clock);
        #1;
        cyc++;
        e_resp = m_pend && (cyc == m_due);
        e_rd   = e_resp ? m_data : 32'h0;
        if (chk_model) begin
            chk($sformatf("c%0d.respValid", cyc), {31'b0, respValid}, {31'b0, e_resp});
            chk($sformatf("c%0d.rdata", cyc), rdata, e_rd);
            chk($sformatf("c%0d.err_overrun", cyc), {31'b0, err_overrun}, {31'b0, m_ovr});
            chk($sformatf("c%0d.err_misalign", cyc), {31'b0, err_misalign}, {31'b0, m_mis});
        end
        if (m_pend && cyc >= m_due) m_pend = 0;
        reqValid = rq; addr = a; size = sz; wen = we; wdata = wd; wmask = wm;
        if (rq) begin
            if (m_pend) begin
                m_ovr = 1;
            end else begin
                ix = m_idx(a);
                if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00))
                    m_mis = 1;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) m_mem[ix][8*b +: 8] = wd[8*b +: 8];
                    m_data = 32'h0;
                end else begin
                    m_data = m_mem[ix];
                end
                m_pend = 1;
                m_due  = cyc + LAT;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0);
    endtask

    // Issue one request and wait a bounded number of cycles for its response.
    task automatic txn_wait(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] wm, output int lat, output logic [31:0] rd);
        bit got;
        step(1'b1, a, 2'd2, we, wd, wm);
        got = 0; lat = 0; rd = 32'h0;
        for (int k = 1; k <= LAT + 5 && !got; k++) begin
            idle();
            if (respValid) begin
                got = 1; lat = k; rd = rdata;
            end
        end
        if (!got) chk("txn_timeout", 32'h0, 32'h1);
        m_pend = 0;
    endtask

    typedef struct {
        logic        rq;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        e_resp;
        logic [31:0] e_rd;
        logic        e_ovr;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(logic rq, logic [31:0] a, logic [1:0] sz, logic we,
                                logic [31:0] wd, logic [3:0] wm, logic er,
                                logic [31:0] erd, logic eo, logic em);
        vec_t v;
        v.rq = rq; v.a = a; v.sz = sz; v.we = we; v.wd = wd; v.wm = wm;
        v.e_resp = er; v.e_rd = erd; v.e_ovr = eo; v.e_mis = em;
        return v;
    endfunction

    vec_t tbl [23];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] a;
        int          r;

`ifdef RAND_LAT_EN
        chk_model = 0;
`else
        chk_model = 1;
`endif
        // One row per cycle: inputs driven in that cycle, outputs expected in it.
        tbl[0]  = mk(1, 32'h8000_0010, 2, 1, 32'h1122_3344, 4'hF, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[2]  = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 32'h0, 0, 0);
        tbl[3]  = mk(1, 32'h8000_0010, 2, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[4]  = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[5]  = mk(1, 32'h8000_0010, 2, 1, 32'h00AB_0000, 4'b0100, 1, 32'h1122_3344, 0, 0);
        tbl[6]  = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[7]  = mk(1, 32'h8000_0010, 2, 0, 32'h0, 4'h0, 1, 32'h0, 0, 0);
        tbl[8]  = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[9]  = mk(1, 32'h8000_0010, 2, 0, 32'h0, 4'h0, 1, 32'h11AB_3344, 0, 0);
        tbl[10] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        tbl[11] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 32'h11AB_3344, 0, 0);
        tbl[12] = mk(1, 32'h8000_0000, 2, 1, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 0, 0);
        tbl[13] = mk(1, 32'h8000_0010, 2, 1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0, 0);
        tbl[14] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 32'h0, 1, 0);
        tbl[15] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0);
        tbl[16] = mk(1, 32'h8000_0010, 2, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0);
        tbl[17] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0);
        tbl[18] = mk(1, 32'h8000_0012, 2, 0, 32'h0, 4'h0, 1, 32'h11AB_3344, 1, 0);
        tbl[19] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 1, 1);
        tbl[20] = mk(1, 32'h8000_1000, 2, 0, 32'h0, 4'h0, 1, 32'h11AB_3344, 1, 1);
        tbl[21] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0, 1, 1);
        tbl[22] = mk(0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1, 1);

        reset_n = 1'b0;
        reqValid = 1'b0; addr = 32'h0; size = 2'd0; wen = 1'b0; wdata = 32'h0; wmask = 4'h0;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset.respValid", {31'b0, respValid}, 32'h0);
        chk("reset.rdata", rdata, 32'h0);
        chk("reset.err_overrun", {31'b0, err_overrun}, 32'h0);
        chk("reset.err_misalign", {31'b0, err_misalign}, 32'h0);
        reset_n = 1'b1;

`ifndef RAND_LAT_EN
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rq, tbl[i].a, tbl[i].sz, tbl[i].we, tbl[i].wd, tbl[i].wm);
            chk($sformatf("tbl%0d.respValid", i), {31'b0, respValid}, {31'b0, tbl[i].e_resp});
            chk($sformatf("tbl%0d.rdata", i), rdata, tbl[i].e_rd);
            chk($sformatf("tbl%0d.err_overrun", i), {31'b0, err_overrun}, {31'b0, tbl[i].e_ovr});
            chk($sformatf("tbl%0d.err_misalign", i), {31'b0, err_misalign}, {31'b0, tbl[i].e_mis});
        end
`endif

        // Store accepted, then reset asserted mid-transaction while BUSY.
        step(1'b1, 32'h8000_0020, 2'd2, 1'b1, 32'h5A5A_1234, 4'hF);
        idle();
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("midrst.respValid", {31'b0, respValid}, 32'h0);
        chk("midrst.rdata", rdata, 32'h0);
        chk("midrst.err_overrun", {31'b0, err_overrun}, 32'h0);
        chk("midrst.err_misalign", {31'b0, err_misalign}, 32'h0);
        idle();
        idle();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle();
            chk($sformatf("midrst.noresp%0d", k), {31'b0, respValid}, 32'h0);
        end
        txn_wait(32'h8000_0020, 1'b0, 32'h0, 4'h0, lat, rd);
        chk("midrst.committed", rd, 32'h5A5A_1234);

        for (int i = 0; i < 16; i++) begin
            txn_wait(BASE + 32'(i * 4), 1'b1, $urandom, 4'hF, lat, rd);
        end

`ifndef RAND_LAT_EN
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 15);
            a = BASE + 32'(r * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH);
            if ($urandom_range(0, 1) == 0) begin
                step(1'b1, a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     $urandom, 4'($urandom_range(0, 15)));
            end else begin
                idle();
            end
        end
`else
        for (int k = 0; k < 100; k++) begin
            r = $urandom_range(0, 15);
            txn_wait(BASE + 32'(r * 4), 1'b0, 32'h0, 4'h0, lat, rd);
            chk($sformatf("rl%0d.lat_lo", k), {31'b0, lat >= LAT}, 32'h1);
            chk($sformatf("rl%0d.lat_hi", k), {31'b0, lat <= LAT + 3}, 32'h1);
            chk($sformatf("rl%0d.rdata", k), rd, m_mem[r]);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
